// File: rtl/fpmul_share_ctrl.sv
// Shares one free-running pipelined FP multiplier between N_REQ requesters.
// A round-robin arbiter picks one operand pair per cycle. A tag shift register
// follows each operation through the multiplier. A credit-checked result FIFO
// absorbs output backpressure, so the multiplier never has to stall.
module fpmul_share_ctrl #(
    parameter int N_REQ     = 2,
    parameter int PIPE_LAT  = 4,
    parameter int RES_DEPTH = 8,   // must be >= PIPE_LAT+1
    parameter int TAG_W     = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     in_valid,
    output logic [N_REQ-1:0]     in_ready,
    input  logic [32*N_REQ-1:0]  in_a,
    input  logic [32*N_REQ-1:0]  in_b,
    output logic [31:0]          mul_a,
    output logic [31:0]          mul_b,
    input  logic [31:0]          mul_z,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_data,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 busy
);

    localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int CNT_W = $clog2(RES_DEPTH + 1);

    // Unpacked views of the per-requester operand buses
    logic [31:0] a_arr [N_REQ];
    logic [31:0] b_arr [N_REQ];

    // Arbiter state and decisions
    logic [TAG_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic             grant_valid;
    logic [TAG_W-1:0] grant_idx;
    logic             issue_ok;
    int               inflight;

    // Operand register feeding the multiplier
    logic [31:0] mul_a_reg, mul_b_reg;

    // Tag pipeline: stage 0 sits alongside the operand register, stage
    // PIPE_LAT lines up with mul_z being valid.
    logic [PIPE_LAT:0] tag_valid_reg;
    logic [TAG_W-1:0]  tag_id_reg [PIPE_LAT+1];

    // Result FIFO, each entry {tag, product}
    logic [TAG_W+31:0] fifo_mem [RES_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              push, pop, fifo_full;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign a_arr[gi]    = in_a[32*gi +: 32];
            assign b_arr[gi]    = in_b[32*gi +: 32];
            assign in_ready[gi] = grant_valid && (grant_idx == TAG_W'(gi));
        end
    endgenerate

    // Count operations that already hold a reserved FIFO slot
    always_comb begin
        inflight = 0;
        for (int k = 0; k <= PIPE_LAT; k++) begin
            inflight += int'(tag_valid_reg[k]);
        end
    end

    // Issue only while buffered plus in-flight results leave a free slot
    assign issue_ok = !rst && ((int'(count_reg) + inflight) < RES_DEPTH);

    // Round-robin scan from the pointer upward with wrap
    always_comb begin
        int idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!grant_valid && issue_ok && in_valid[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = TAG_W'(idx);
            end
        end
    end

    // Pointer moves just past the requester that was served
    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (grant_valid) begin
            if (grant_idx == TAG_W'(N_REQ - 1)) begin
                rr_ptr_next = '0;
            end else begin
                rr_ptr_next = grant_idx + 1'b1;
            end
        end
    end

    // Operand register, tag pipeline and arbiter pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg    <= '0;
            mul_a_reg     <= '0;
            mul_b_reg     <= '0;
            tag_valid_reg <= '0;
            for (int k = 0; k <= PIPE_LAT; k++) begin
                tag_id_reg[k] <= '0;
            end
        end else begin
            rr_ptr_reg       <= rr_ptr_next;
            mul_a_reg        <= grant_valid ? a_arr[grant_idx] : 32'h0;
            mul_b_reg        <= grant_valid ? b_arr[grant_idx] : 32'h0;
            tag_valid_reg[0] <= grant_valid;
            tag_id_reg[0]    <= grant_valid ? grant_idx : '0;
            for (int k = 1; k <= PIPE_LAT; k++) begin
                tag_valid_reg[k] <= tag_valid_reg[k-1];
                tag_id_reg[k]    <= tag_id_reg[k-1];
            end
        end
    end

    assign mul_a = mul_a_reg;
    assign mul_b = mul_b_reg;

    assign push      = tag_valid_reg[PIPE_LAT];
    assign out_valid = (count_reg != '0);
    assign pop       = out_valid && out_ready;
    assign fifo_full = (count_reg == CNT_W'(RES_DEPTH));

    // FIFO storage; contents need no reset because the count gates reads
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_mem[wr_ptr_reg] <= {tag_id_reg[PIPE_LAT], mul_z};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(RES_DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(RES_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Head entry falls through; forced to zero while empty
    assign out_data = out_valid ? fifo_mem[rd_ptr_reg][31:0] : 32'h0;
    assign out_tag  = out_valid ? fifo_mem[rd_ptr_reg][TAG_W+31:32] : '0;

    assign busy = !rst && ((inflight != 0) || (count_reg != '0));

    // Credits make this unreachable; a push into a full FIFO that is not
    // popping the same cycle would lose a product.
    assert property (@(posedge clk) disable iff (rst) !(push && !pop && fifo_full));

endmodule

// File: doc/fpmul_share_ctrl.md
Name: fpmul_share_ctrl

Overview:
- Shares one free-running, non-stallable pipelined FP multiplier (FPmul: FP_A, FP_B in, FP_Z out, fixed latency) between N_REQ requesters.
- Each requester has a valid/ready operand port. Results return on a single tagged valid/ready output port, in issue order.
- A round-robin arbiter picks the next operand pair. A tag shift register tracks in-flight operations. A credit-checked result FIFO absorbs output backpressure so the multiplier pipeline never has to stall.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- PIPE_LAT, 4, cycles from mul_a/mul_b presented to mul_z valid. Must match the FPmul instance.
- RES_DEPTH, 8, result FIFO depth. Must be >= PIPE_LAT+1.
- TAG_W, 1, requester-id width. Equals clog2(N_REQ), minimum 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  N_REQ  per-requester operand valid.
- in_ready  out  N_REQ  per-requester accept. One-hot or zero.
- in_a  in  32*N_REQ  operand A, IEEE-754 single. Requester i occupies bits [32i+31:32i].
- in_b  in  32*N_REQ  operand B, same packing as in_a.
- mul_a  out  32  to FPmul FP_A. Registered.
- mul_b  out  32  to FPmul FP_B. Registered.
- mul_z  in  32  from FPmul FP_Z.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  32  product.
- out_tag  out  TAG_W  index of the requester that issued the product.
- busy  out  1  any operation in flight or any result buffered.

Behaviour:
- Reset, synchronous:
  - mul_a = mul_b = 0.
  - Tag shift register all invalid.
  - FIFO emptied: out_valid = 0, out_data = 0, out_tag = 0.
  - RR pointer = 0, so requester 0 has highest priority.
  - busy = 0, in_ready = 0 during the reset cycle.
- Reset mid-operation discards all in-flight and buffered results. Nothing is emitted afterwards for them.
- Credits:
  - credits = RES_DEPTH - fifo_count - inflight.
  - inflight = number of valid entries in the operand stage plus the PIPE_LAT-deep tag shift register.
  - Issue is allowed only when credits > 0. This guarantees every product has a FIFO slot.
- Arbitration (combinational):
  - When issue is allowed, grant goes to the first requester with in_valid=1, scanning from RR pointer upward with wrap.
  - in_ready[grant] = 1; all other in_ready bits = 0.
  - in_ready may depend on in_valid. Requesters must not make in_valid depend on in_ready.
- Accept cycle T (in_valid[g] & in_ready[g]):
  - At edge T, the operand register loads in_a[g]/in_b[g] and the tag stage loads {valid=1, tag=g}.
  - The RR pointer moves to (g+1) mod N_REQ.
  - With no accept, the operand register loads 0 and a tag stage with valid=0. The pointer holds.
- Pipeline:
  - mul_a/mul_b are valid during cycle T+1.
  - The tag shifts one stage per cycle, unconditionally.
  - mul_z is valid during cycle T+1+PIPE_LAT. At that edge, mul_z and its tag are pushed into the FIFO.
- Output:
  - FIFO is first-word-fall-through from its registers.
  - Into an empty FIFO with out_ready=1, out_valid rises in cycle T+2+PIPE_LAT. Minimum latency is PIPE_LAT+2 cycles.
  - Pop occurs on out_valid & out_ready.
  - out_data/out_tag hold stable while out_valid=1 and out_ready=0.
- FIFO boundaries:
  - Simultaneous push and pop on a full or empty FIFO is legal; count is unchanged.
  - Pointers wrap modulo RES_DEPTH.
  - Overflow is impossible by credit. An assertion flags push-while-full.
- Throughput: one issue per cycle whenever credits > 0. With out_ready held at 1, sustained rate is 1/cycle.
- Ordering: results leave strictly in issue order. out_tag identifies the requester.
- busy = (inflight != 0) | (fifo_count != 0).
- No NaN/denormal handling here; products pass through unmodified.

Test Plan:
- Single op, PIPE_LAT=4, requester 0: in_a=0x3FC00000 (1.5), in_b=0x40000000 (2.0), accepted cycle 10 -> out_valid first high cycle 16 with out_data=0x40400000 (3.0), out_tag=0. busy high from cycle 11 to the pop cycle.
- Both requesters hold in_valid=1 continuously, out_ready=1 -> in_ready alternates 01,10,01,... starting with requester 0 after reset. out_tag alternates 0,1,0,... with one result per cycle.
- out_ready=0 from cycle 0, requester 1 streaming, RES_DEPTH=8 -> exactly 8 accepts, then in_ready stays 0. The FIFO fills with no lost or duplicated result. Raising out_ready drains 8 results in order, then accepts resume.
- Backpressure toggle: out_ready alternates 1/0 with continuous issue -> FIFO holds at a steady push/pop balance without overflow. The out_data sequence matches the issue order exactly.
- rst asserted for one cycle while 3 ops are in flight and 2 are buffered -> next cycle out_valid=0, busy=0, mul_a=0. No stale result appears in the following PIPE_LAT+2 cycles. The next grant goes to requester 0.
- Only requester 1 valid with RR pointer=0 -> requester 1 is granted the same cycle (no idle bubble), and the pointer becomes 0.
